// File: rtl/constants.sv
// Shared types and constants for the memory arbiter.
// Contents:
//   DATA_W/ADDR_W - bus widths
//   CNT_W         - wait-state counter width
//   STARVE_W      - DMA starvation counter width
//   arb_state_t   - arbiter FSM states
//   bus_owner_t   - which requester owns the memory bus
//   controlPts    - per-cycle control points from the FSM to the datapath
package constants;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int CNT_W    = 4;
  localparam int STARVE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } bus_owner_t;

  typedef struct packed {
    logic       grant;        // latch a new access this edge
    bus_owner_t grant_owner;  // winner of the arbitration
    logic       grant_write;  // direction of the granted access
    logic       count_dec;    // step the wait-state counter
    logic       capture;      // last access cycle: sample memRData
  } controlPts;

endpackage

// File: rtl/wait_counter.sv
// Wait-state down-counter for the memory arbiter.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   load         - load load_val (takes priority over dec)
//   load_val     - value loaded on load
//   dec          - decrement by one; holds at zero rather than wrapping
//   zero         - counter currently equals zero
module wait_counter
  import constants::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU / DMA) single-port memory arbiter.
// The CPU has strict priority unless built with MEM_ARB_STARVE_GUARD_EN,
// which forces a DMA grant after STARVE_LIMIT consecutive CPU grants made
// while DMA was waiting.
// Ports:
//   clock, reset                      - clock, asynchronous active-high reset
//   cpuRe_L, cpuWe_L                  - CPU read/write requests (active-low)
//   cpuAddr, cpuWData, cpuRData       - CPU address, write data, read data
//   cpuStall                          - CPU request not yet completed
//   dmaReq, dmaWe                     - DMA request and direction (1=write)
//   dmaAddr, dmaWData, dmaRData       - DMA address, write data, read data
//   dmaAck                            - one-cycle DMA completion pulse
//   memAddr, memWData, memRData       - memory address / data
//   memRe_L, memWe_L                  - memory strobes (active-low)
//   busOwner                          - 0=CPU, 1=DMA, current or last access
module mem_arbiter
  import constants::*;
#(
  parameter int WAIT_STATES  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpuRe_L,
  input  logic              cpuWe_L,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic [DATA_W-1:0] cpuRData,
  output logic              cpuStall,
  input  logic              dmaReq,
  input  logic              dmaWe,
  input  logic [ADDR_W-1:0] dmaAddr,
  input  logic [DATA_W-1:0] dmaWData,
  output logic [DATA_W-1:0] dmaRData,
  output logic              dmaAck,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  output logic              memRe_L,
  output logic              memWe_L,
  output logic              busOwner
);

  if (WAIT_STATES < 1 || WAIT_STATES > 15 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_param
    $error("mem_arbiter: WAIT_STATES or STARVE_LIMIT out of range");
  end

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES - 1);

  arb_state_t        state_q, state_d;
  controlPts         ctl;
  bus_owner_t        owner_q;
  logic              write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] dma_rdata_q;
  logic              cnt_zero;
  logic              cpu_req;
  logic              dma_pick;

  // Both strobes low counts as a request (and as a write).
  assign cpu_req = !cpuRe_L || !cpuWe_L;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [STARVE_W-1:0] starve_q;

  // Counts CPU wins taken while DMA was waiting; any DMA win clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if (ctl.grant) begin
      if (ctl.grant_owner == OWN_DMA) begin
        starve_q <= '0;
      end else if (dmaReq) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

  assign dma_pick = dmaReq && (!cpu_req || (starve_q == STARVE_W'(STARVE_LIMIT)));
`else
  assign dma_pick = dmaReq && !cpu_req;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath control points
  always_comb begin
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      IDLE: begin
        if (dma_pick) begin
          ctl.grant       = 1'b1;
          ctl.grant_owner = OWN_DMA;
          ctl.grant_write = dmaWe;
          state_d         = ACCESS;
        end else if (cpu_req) begin
          ctl.grant       = 1'b1;
          ctl.grant_owner = OWN_CPU;
          ctl.grant_write = !cpuWe_L;
          state_d         = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_zero) begin
          ctl.capture = 1'b1;
          state_d     = DONE;
        end else begin
          ctl.count_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    memRe_L  = !((state_q == ACCESS) && !write_q);
    memWe_L  = !((state_q == ACCESS) && write_q);
    dmaAck   = (state_q == DONE) && (owner_q == OWN_DMA);
    cpuStall = cpu_req && !((state_q == DONE) && (owner_q == OWN_CPU));
  end

  // Access latch and read-data capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      owner_q     <= OWN_CPU;
      write_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (ctl.grant) begin
        owner_q     <= ctl.grant_owner;
        write_q     <= ctl.grant_write;
        mem_addr_q  <= (ctl.grant_owner == OWN_DMA) ? dmaAddr : cpuAddr;
        mem_wdata_q <= (ctl.grant_owner == OWN_DMA) ? dmaWData : cpuWData;
      end
      if (ctl.capture && !write_q) begin
        if (owner_q == OWN_DMA) begin
          dma_rdata_q <= memRData;
        end else begin
          cpu_rdata_q <= memRData;
        end
      end
    end
  end

  wait_counter u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (ctl.grant),
    .load_val (WAIT_LOAD),
    .dec      (ctl.count_dec),
    .zero     (cnt_zero)
  );

  assign memAddr  = mem_addr_q;
  assign memWData = mem_wdata_q;
  assign cpuRData = cpu_rdata_q;
  assign dmaRData = dma_rdata_q;
  assign busOwner = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (WAIT_STATES=2, STARVE_LIMIT=4).
// Cycle-by-cycle vector table followed by starvation and reset sequences.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpuRe_L = 1'b1, cpuWe_L = 1'b1;
  logic [15:0] cpuAddr = '0, cpuWData = '0;
  logic [15:0] cpuRData;
  logic        cpuStall;
  logic        dmaReq = 1'b0, dmaWe = 1'b0;
  logic [15:0] dmaAddr = '0, dmaWData = '0;
  logic [15:0] dmaRData;
  logic        dmaAck;
  logic [15:0] memAddr, memWData;
  logic [15:0] memRData = '0;
  logic        memRe_L, memWe_L;
  logic        busOwner;

  mem_arbiter #(.WAIT_STATES(2), .STARVE_LIMIT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .cpuRe_L  (cpuRe_L),
    .cpuWe_L  (cpuWe_L),
    .cpuAddr  (cpuAddr),
    .cpuWData (cpuWData),
    .cpuRData (cpuRData),
    .cpuStall (cpuStall),
    .dmaReq   (dmaReq),
    .dmaWe    (dmaWe),
    .dmaAddr  (dmaAddr),
    .dmaWData (dmaWData),
    .dmaRData (dmaRData),
    .dmaAck   (dmaAck),
    .memAddr  (memAddr),
    .memWData (memWData),
    .memRData (memRData),
    .memRe_L  (memRe_L),
    .memWe_L  (memWe_L),
    .busOwner (busOwner)
  );

  always #5 clock = ~clock;

  // {memRe_L, memWe_L, memAddr, memWData, cpuRData, dmaRData, cpuStall, dmaAck, busOwner}
  logic [68:0] act;
  assign act = {memRe_L, memWe_L, memAddr, memWData, cpuRData, dmaRData, cpuStall, dmaAck, busOwner};

  typedef struct {
    logic        re_l, we_l;
    logic [15:0] caddr, cwd;
    logic        dreq, dwe;
    logic [15:0] daddr, dwd, mrd;
    logic [68:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic re_l, input logic we_l, input logic [15:0] caddr, input logic [15:0] cwd,
                     input logic dreq, input logic dwe, input logic [15:0] daddr, input logic [15:0] dwd,
                     input logic [15:0] mrd,
                     input logic e_re, input logic e_we, input logic [15:0] e_addr, input logic [15:0] e_wd,
                     input logic [15:0] e_crd, input logic [15:0] e_drd,
                     input logic e_stall, input logic e_ack, input logic e_own);
    vec_t v;
    v.re_l = re_l; v.we_l = we_l; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
    v.exp  = {e_re, e_we, e_addr, e_wd, e_crd, e_drd, e_stall, e_ack, e_own};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [68:0] got, input logic [68:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  initial begin
    int          idx;
    logic        prev_act, now_act, exp_own;

    //    re we caddr   cwd     dq dw daddr   dwd     mrd       | Re We addr    wd      crd     drd     st ak ow
    add(1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
    // CPU read of 0x0040
    add(0, 1, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,  1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 1, 16'h9999, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,  0, 1, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 1, 16'h9999, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,  0, 1, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0);
    add(0, 1, 16'h9999, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hBEEF,  1, 1, 16'h0040, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 0);
    add(1, 1, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 1, 16'h0040, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 0);
    // CPU write 0x1234 -> 0x0100 while DMA write waits
    add(1, 0, 16'h0100, 16'h1234, 1, 1, 16'h0200, 16'h5555, 16'h0000,  1, 1, 16'h0040, 16'h0000, 16'hBEEF, 16'h0000, 1, 0, 0);
    add(1, 0, 16'h0100, 16'h1234, 1, 1, 16'h0200, 16'h5555, 16'h0000,  1, 0, 16'h0100, 16'h1234, 16'hBEEF, 16'h0000, 1, 0, 0);
    add(1, 0, 16'h0100, 16'h1234, 1, 1, 16'h0200, 16'h5555, 16'h0000,  1, 0, 16'h0100, 16'h1234, 16'hBEEF, 16'h0000, 1, 0, 0);
    add(1, 0, 16'h0100, 16'h1234, 1, 1, 16'h0200, 16'h5555, 16'h0000,  1, 1, 16'h0100, 16'h1234, 16'hBEEF, 16'h0000, 0, 0, 0);
    add(1, 1, 16'h0000, 16'h0000, 1, 1, 16'h0200, 16'h5555, 16'h0000,  1, 1, 16'h0100, 16'h1234, 16'hBEEF, 16'h0000, 0, 0, 0);
    add(1, 1, 16'h0000, 16'h0000, 1, 1, 16'h0200, 16'h5555, 16'h0000,  1, 0, 16'h0200, 16'h5555, 16'hBEEF, 16'h0000, 0, 0, 1);
    add(1, 1, 16'h0000, 16'h0000, 1, 1, 16'h0200, 16'h5555, 16'h0000,  1, 0, 16'h0200, 16'h5555, 16'hBEEF, 16'h0000, 0, 0, 1);
    add(1, 1, 16'h0000, 16'h0000, 0, 1, 16'h0200, 16'h5555, 16'h0000,  1, 1, 16'h0200, 16'h5555, 16'hBEEF, 16'h0000, 0, 1, 1);
    add(1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 1, 16'h0200, 16'h5555, 16'hBEEF, 16'h0000, 0, 0, 1);
    // DMA read of 0x0200, request dropped right after grant
    add(1, 1, 16'h0000, 16'h0000, 1, 0, 16'h0200, 16'h5555, 16'hCAFE,  1, 1, 16'h0200, 16'h5555, 16'hBEEF, 16'h0000, 0, 0, 1);
    add(1, 1, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0000, 16'hCAFE,  0, 1, 16'h0200, 16'h5555, 16'hBEEF, 16'h0000, 0, 0, 1);
    add(1, 1, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0000, 16'hCAFE,  0, 1, 16'h0200, 16'h5555, 16'hBEEF, 16'h0000, 0, 0, 1);
    add(1, 1, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 16'h0000, 16'hCAFE,  1, 1, 16'h0200, 16'h5555, 16'hBEEF, 16'hCAFE, 0, 1, 1);
    add(1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 1, 16'h0200, 16'h5555, 16'hBEEF, 16'hCAFE, 0, 0, 1);
    // Both CPU strobes low -> write
    add(0, 0, 16'h0300, 16'hA5A5, 0, 0, 16'h0000, 16'h0000, 16'h1111,  1, 1, 16'h0200, 16'h5555, 16'hBEEF, 16'hCAFE, 1, 0, 1);
    add(0, 0, 16'h0300, 16'hA5A5, 0, 0, 16'h0000, 16'h0000, 16'h1111,  1, 0, 16'h0300, 16'hA5A5, 16'hBEEF, 16'hCAFE, 1, 0, 0);
    add(0, 0, 16'h0300, 16'hA5A5, 0, 0, 16'h0000, 16'h0000, 16'h1111,  1, 0, 16'h0300, 16'hA5A5, 16'hBEEF, 16'hCAFE, 1, 0, 0);
    add(1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h1111,  1, 1, 16'h0300, 16'hA5A5, 16'hBEEF, 16'hCAFE, 0, 0, 0);
    add(1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000,  1, 1, 16'h0300, 16'hA5A5, 16'hBEEF, 16'hCAFE, 0, 0, 0);

    // Reset held over two edges, released mid-cycle
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clock);
      #1;
      cpuRe_L  = vecs[i].re_l;  cpuWe_L  = vecs[i].we_l;
      cpuAddr  = vecs[i].caddr; cpuWData = vecs[i].cwd;
      dmaReq   = vecs[i].dreq;  dmaWe    = vecs[i].dwe;
      dmaAddr  = vecs[i].daddr; dmaWData = vecs[i].dwd;
      memRData = vecs[i].mrd;
      #1;
      check($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // Continuous CPU and DMA read requests: observe owner of each completed access
    cpuRe_L = 1'b0; cpuWe_L = 1'b1; cpuAddr = 16'h0500;
    dmaReq  = 1'b1; dmaWe   = 1'b0; dmaAddr = 16'h0600;
    memRData = 16'h2222;
    idx = 0;
    prev_act = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock);
      #2;
      now_act = !memRe_L || !memWe_L;
      if (prev_act && !now_act) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_own = ((idx % 5) == 4);
`else
        exp_own = 1'b0;
`endif
        check($sformatf("starve_owner%0d", idx), 69'(busOwner), 69'(exp_own));
        idx++;
      end
      prev_act = now_act;
    end
    check("starve_access_count", 69'(idx >= 12), 69'(1));

    cpuRe_L = 1'b1; dmaReq = 1'b0;
    repeat (6) @(posedge clock);

    // Reset in the second ACCESS cycle of a DMA read
    #1;
    dmaReq = 1'b1; dmaWe = 1'b0; dmaAddr = 16'h0400; memRData = 16'h7777;
    @(posedge clock);
    #1;
    dmaReq = 1'b0;
    @(posedge clock);
    #1;
    check("rst_pre_strobe", 69'({memRe_L, memAddr}), 69'({1'b0, 16'h0400}));
    reset = 1'b1;
    #1;
    check("rst_async", 69'({memRe_L, memWe_L, dmaAck, cpuRData, dmaRData, memAddr, busOwner}),
          69'({1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}));
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1;
      check($sformatf("rst_after%0d", c), 69'({memRe_L, memWe_L, dmaAck, dmaRData, cpuStall}),
            69'({1'b1, 1'b1, 1'b0, 16'h0000, 1'b0}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
